// File: rtl/alu_issue_ctrl.sv
// Operand-fetch / writeback stage wrapped around a combinational 8-bit ALU.
// Issues one instruction per handshake, holds operands ALU_WAIT cycles, then captures Result and NZVC.
module alu_issue_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ALU_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_wb,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        ALU_Sel,
  input  logic [DATA_W-1:0] Result,
  input  logic [3:0]        NZVC,
  output logic [3:0]        flags,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int         NREG      = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   rd_q;
  logic                wb_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2:0]          sel_q;
  logic [3:0]          flags_q;
  logic                ready_q;
  logic                done_q;

  // Issue/capture FSM; operands are read at accept so the previous writeback is always visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= {ADDR_W{1'b0}};
      wb_q    <= 1'b0;
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
      sel_q   <= 3'd0;
      flags_q <= 4'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (instr_valid) begin
            a_q     <= regs_q[instr_rs1];
            b_q     <= instr_use_imm ? instr_imm : regs_q[instr_rs2];
            sel_q   <= instr_op;
            rd_q    <= instr_rd;
            wb_q    <= instr_wb;
            cnt_q   <= WAIT_LOAD;
            ready_q <= 1'b0;
            state_q <= ST_ISSUE;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          ready_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            flags_q <= NZVC;
            if (wb_q) begin
              regs_q[rd_q] <= Result;
            end else begin
              regs_q[rd_q] <= regs_q[rd_q];
            end
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            done_q  <= 1'b0;
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign A           = a_q;
  assign B           = b_q;
  assign ALU_Sel     = sel_q;
  assign flags       = flags_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule
